// File: rtl/pd_duty_controller.sv
// Incremental PD speed-loop controller: a 4-state pipeline turns each sample_tick into a
// clamped duty update, and a free-running PWM counter drives pwm_out from that duty.
module pd_duty_controller #(
  parameter int SHIFT      = 2,
  parameter int DUTY_MAX   = 1023,
  parameter int PWM_PERIOD = 1024
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       enable,
  input  logic       sample_tick,
  input  logic [9:0] target_vel,
  input  logic [9:0] current_vel,
  input  logic [3:0] Kp,
  input  logic [3:0] Kd,
  output logic [9:0] duty,
  output logic       duty_valid,
  output logic       busy,
  output logic       pwm_out
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ERR  = 2'd1,
    MUL  = 2'd2,
    SUM  = 2'd3
  } state_t;

  localparam logic signed [17:0] DUTY_MAX_S = 18'(DUTY_MAX);
  localparam logic [9:0]         CNT_LAST   = 10'(PWM_PERIOD - 1);

  state_t             state_reg;
  logic [9:0]         tgt_reg;
  logic [9:0]         cur_reg;
  logic [3:0]         kp_reg;
  logic [3:0]         kd_reg;
  logic signed [10:0] error_reg;
  logic signed [10:0] prev_error_reg;
  logic signed [11:0] d_err_reg;
  logic signed [15:0] p_reg;
  logic signed [15:0] d_reg;
  logic [9:0]         duty_reg;
  logic               duty_valid_reg;
  logic               busy_reg;

  logic [9:0]         cnt_reg;
  logic [10:0]        active_duty_reg;
  logic               enable_reg;

  // ERR stage arithmetic
  logic signed [10:0] error_next;
  logic signed [11:0] d_err_next;

  assign error_next = $signed({1'b0, tgt_reg}) - $signed({1'b0, cur_reg});
  assign d_err_next = $signed({error_next[10], error_next})
                    - $signed({prev_error_reg[10], prev_error_reg});

  // MUL stage: gains are unsigned, so they are zero-extended into the signed product
  logic signed [15:0] kp_ext;
  logic signed [15:0] kd_ext;
  logic signed [15:0] error_ext;
  logic signed [15:0] d_err_ext;
  logic signed [15:0] p_next;
  logic signed [15:0] d_next;

  assign kp_ext    = $signed({12'd0, kp_reg});
  assign kd_ext    = $signed({12'd0, kd_reg});
  assign error_ext = $signed({{5{error_reg[10]}}, error_reg});
  assign d_err_ext = $signed({{4{d_err_reg[11]}}, d_err_reg});
  assign p_next    = kp_ext * error_ext;
  assign d_next    = kd_ext * d_err_ext;

  // SUM stage: one extra bit keeps p+d from overflowing before the shift
  logic signed [16:0] pd_sum;
  logic signed [16:0] pd_shift;
  logic signed [17:0] acc;
  logic [9:0]         duty_clamped;

  assign pd_sum   = $signed({p_reg[15], p_reg}) + $signed({d_reg[15], d_reg});
  assign pd_shift = pd_sum >>> SHIFT;
  assign acc      = $signed({8'd0, duty_reg}) + $signed({pd_shift[16], pd_shift});

  always_comb begin
    duty_clamped = acc[9:0];
    if (acc < 18'sd0) begin
      duty_clamped = 10'd0;
    end else if (acc > DUTY_MAX_S) begin
      duty_clamped = DUTY_MAX_S[9:0];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg      <= IDLE;
      tgt_reg        <= '0;
      cur_reg        <= '0;
      kp_reg         <= '0;
      kd_reg         <= '0;
      error_reg      <= '0;
      prev_error_reg <= '0;
      d_err_reg      <= '0;
      p_reg          <= '0;
      d_reg          <= '0;
      duty_reg       <= '0;
      duty_valid_reg <= 1'b0;
      busy_reg       <= 1'b0;
    end else begin
      duty_valid_reg <= 1'b0;
      if (!enable) begin
        // Abandon any in-flight update; the loop restarts with no derivative history
        state_reg      <= IDLE;
        busy_reg       <= 1'b0;
        prev_error_reg <= '0;
      end else begin
        case (state_reg)
          IDLE: begin
            if (sample_tick) begin
              tgt_reg   <= target_vel;
              cur_reg   <= current_vel;
              kp_reg    <= Kp;
              kd_reg    <= Kd;
              state_reg <= ERR;
              busy_reg  <= 1'b1;
            end
          end
          ERR: begin
            error_reg <= error_next;
            d_err_reg <= d_err_next;
            state_reg <= MUL;
          end
          MUL: begin
            p_reg     <= p_next;
            d_reg     <= d_next;
            state_reg <= SUM;
          end
          SUM: begin
            duty_reg       <= duty_clamped;
            duty_valid_reg <= 1'b1;
            prev_error_reg <= error_reg;
            state_reg      <= IDLE;
            busy_reg       <= 1'b0;
          end
          default: begin
            state_reg <= IDLE;
            busy_reg  <= 1'b0;
          end
        endcase
      end
    end
  end

  // Active duty only reloads at the period boundary so pwm_out never glitches mid-period
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_reg         <= '0;
      active_duty_reg <= '0;
      enable_reg      <= 1'b0;
    end else begin
      enable_reg <= enable;
      if (cnt_reg == CNT_LAST) begin
        cnt_reg         <= '0;
        active_duty_reg <= {1'b0, duty_reg};
      end else begin
        cnt_reg <= cnt_reg + 10'd1;
      end
    end
  end

  assign pwm_out    = ({1'b0, cnt_reg} < active_duty_reg) && enable_reg;
  assign duty       = duty_reg;
  assign duty_valid = duty_valid_reg;
  assign busy       = busy_reg;

endmodule

// File: tb/tb_pd_duty_controller.sv
// Randomized bench for pd_duty_controller: a plain-arithmetic PD model predicts every duty
// update, and PWM high time is measured over whole periods.
module tb_pd_duty_controller;

  logic       clk;
  logic       rst_n;
  logic       enable;
  logic       sample_tick;
  logic [9:0] target_vel;
  logic [9:0] current_vel;
  logic [3:0] Kp;
  logic [3:0] Kd;
  logic [9:0] duty;
  logic       duty_valid;
  logic       busy;
  logic       pwm_out;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state
  int m_duty = 0;
  int m_prev = 0;

  pd_duty_controller #(
    .SHIFT(2),
    .DUTY_MAX(1023),
    .PWM_PERIOD(1024)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .enable(enable),
    .sample_tick(sample_tick),
    .target_vel(target_vel),
    .current_vel(current_vel),
    .Kp(Kp),
    .Kd(Kd),
    .duty(duty),
    .duty_valid(duty_valid),
    .busy(busy),
    .pwm_out(pwm_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // PD law straight from the rules: error, derivative, gains, shift, clamp
  task automatic predict(input int tgt, input int cur, input int kp, input int kd,
                         output int exp);
    int err;
    int derr;
    int acc;
    err  = tgt - cur;
    derr = err - m_prev;
    acc  = m_duty + ((kp * err + kd * derr) >>> 2);
    if (acc < 0) acc = 0;
    if (acc > 1023) acc = 1023;
    m_prev = err;
    m_duty = acc;
    exp    = acc;
  endtask

  // Starts and ends just after a falling edge; the tick is sampled on the next rising edge
  task automatic run_tick(input int tgt, input int cur, input int kp, input int kd,
                          input string tag, input int lit);
    int exp;
    target_vel  = 10'(tgt);
    current_vel = 10'(cur);
    Kp          = 4'(kp);
    Kd          = 4'(kd);
    sample_tick = 1'b1;
    predict(tgt, cur, kp, kd, exp);
    @(negedge clk);
    sample_tick = 1'b0;
    check_val({tag, ".busy_t0"}, busy, 1);
    check_val({tag, ".valid_t0"}, duty_valid, 0);
    @(negedge clk);
    check_val({tag, ".valid_t1"}, duty_valid, 0);
    @(negedge clk);
    check_val({tag, ".valid_t2"}, duty_valid, 0);
    @(negedge clk);
    check_val({tag, ".valid_t3"}, duty_valid, 1);
    check_val({tag, ".busy_t3"}, busy, 0);
    check_val({tag, ".duty"}, duty, exp);
    if (lit >= 0) check_val({tag, ".duty_lit"}, duty, lit);
    $display("[TB] tick %s tgt=%0d cur=%0d kp=%0d kd=%0d duty=%0d exp=%0d",
             tag, tgt, cur, kp, kd, duty, exp);
  endtask

  // Any 1024 consecutive cycles with a stable active duty contain exactly duty high cycles
  task automatic pwm_count(input string tag, input int exp);
    int n;
    n = 0;
    repeat (1030) @(negedge clk);
    repeat (1024) begin
      @(negedge clk);
      n += int'(pwm_out);
    end
    check_val(tag, n, exp);
    $display("[TB] pwm %s high=%0d exp=%0d", tag, n, exp);
  endtask

  initial begin
    int nv;
    int exp;
    int tgt;
    int cur;

    rst_n       = 1'b0;
    enable      = 1'b0;
    sample_tick = 1'b0;
    target_vel  = '0;
    current_vel = '0;
    Kp          = '0;
    Kd          = '0;

    repeat (3) @(negedge clk);
    check_val("rst.duty", duty, 0);
    check_val("rst.valid", duty_valid, 0);
    check_val("rst.busy", busy, 0);
    check_val("rst.pwm", pwm_out, 0);
    rst_n  = 1'b1;
    enable = 1'b1;
    @(negedge clk);
    pwm_count("pwm_zero", 0);

    // Directed PD steps
    run_tick(100, 90, 4, 0, "p_only", 10);
    pwm_count("pwm_10", 10);
    run_tick(100, 90, 4, 2, "d_zero", 20);
    run_tick(100, 95, 4, 2, "d_neg", 22);
    run_tick(0, 1000, 15, 15, "sat_low", 0);
    run_tick(1000, 0, 15, 15, "sat_high", 1023);
    pwm_count("pwm_1023", 1023);

    // A tick held into the busy cycle is ignored, the next one is taken back-to-back
    target_vel  = 10'd500;
    current_vel = 10'd480;
    Kp          = 4'd3;
    Kd          = 4'd1;
    sample_tick = 1'b1;
    predict(500, 480, 3, 1, exp);
    @(negedge clk);
    target_vel = 10'd0;
    nv = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      sample_tick = 1'b0;
      nv += int'(duty_valid);
      if (i == 2) check_val("busy_tick.duty", duty, exp);
    end
    check_val("busy_tick.pulses", nv, 1);
    run_tick(520, 510, 2, 1, "after_busy", -1);
    run_tick(530, 515, 2, 1, "back2back", -1);

    // Drop enable while the FSM sits in MUL
    target_vel  = 10'd600;
    current_vel = 10'd400;
    Kp          = 4'd5;
    Kd          = 4'd7;
    sample_tick = 1'b1;
    @(negedge clk);
    sample_tick = 1'b0;
    @(negedge clk);
    enable = 1'b0;
    @(negedge clk);
    check_val("dis.busy", busy, 0);
    check_val("dis.pwm", pwm_out, 0);
    nv = int'(duty_valid);
    repeat (6) begin
      @(negedge clk);
      nv += int'(duty_valid);
    end
    check_val("dis.pulses", nv, 0);
    check_val("dis.duty_hold", duty, m_duty);
    m_prev = 0;
    nv = 0;
    repeat (1100) begin
      @(negedge clk);
      nv += int'(pwm_out);
    end
    check_val("dis.pwm_low", nv, 0);
    enable = 1'b1;
    @(negedge clk);
    run_tick(200, 300, 0, 8, "reenable", -1);

    // Randomized updates with occasional enable drops and idle gaps
    for (int k = 0; k < 60; k++) begin
      if ($urandom_range(0, 7) == 0) begin
        enable = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check_val("rnd.dis_busy", busy, 0);
        m_prev = 0;
        enable = 1'b1;
        @(negedge clk);
      end
      repeat ($urandom_range(0, 2)) @(negedge clk);
      tgt = int'($urandom_range(0, 1023));
      cur = tgt + int'($urandom_range(0, 120)) - 60;
      if (cur < 0) cur = 0;
      if (cur > 1023) cur = 1023;
      run_tick(tgt, cur, int'($urandom_range(0, 15)), int'($urandom_range(0, 15)),
               "rnd", -1);
    end

    // Reset asserted while the update is in SUM discards it
    run_tick(900, 100, 15, 0, "pre_rst", 1023);
    target_vel  = 10'd100;
    current_vel = 10'd900;
    Kp          = 4'd15;
    Kd          = 4'd15;
    sample_tick = 1'b1;
    @(negedge clk);
    sample_tick = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_val("rst_sum.duty", duty, 0);
    check_val("rst_sum.busy", busy, 0);
    check_val("rst_sum.pwm", pwm_out, 0);
    @(negedge clk);
    rst_n  = 1'b1;
    m_duty = 0;
    m_prev = 0;
    nv = int'(duty_valid);
    repeat (5) begin
      @(negedge clk);
      nv += int'(duty_valid);
    end
    check_val("rst_sum.pulses", nv, 0);
    check_val("rst_sum.duty_after", duty, 0);
    run_tick(300, 280, 4, 4, "post_rst", -1);

    $display("[TB] %0d tests run, %0d failed", n_checks, n_fail);
    $finish;
  end

endmodule
